// File: rtl/io_responder_pkg.sv
// Shared decode constants for the CPU I/O window responder.
package io_pkg;

  localparam logic [1:0] IO_WIN  = 2'b11;
  localparam logic [2:0] IO_UART = 3'd0;
  localparam logic [2:0] IO_CNT0 = 3'd4;
  localparam logic [2:0] IO_CNT1 = 3'd5;
  localparam logic [2:0] IO_CNT2 = 3'd6;
  localparam logic [2:0] IO_CNT3 = 3'd7;

  function automatic logic [7:0] cnt_byte(input logic [31:0] v, input logic [1:0] idx);
    return v[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/io_responder_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; push/pop are self-gated by full/empty and frozen by rdy_i.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rdy_i,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Fullness/emptiness are judged on pre-edge state, so a pop cannot make room for a same-cycle push.
  assign do_push = rdy_i & push_i & ~full_o;
  assign do_pop  = rdy_i & pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/io_responder.sv
// I/O window responder: UART RX/TX FIFOs, tear-free cycle counter and sticky program stop.
module io_responder
  import io_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        io_sel,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);

  logic        io_acc, mapped;
  logic [2:0]  off;
  logic        unused_bits;

  logic [7:0]  rdata_q, rdata_d;
  logic        sel_q, sel_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;
  logic        stop_q, stop_d;
  logic        ovf_q, ovf_d;

  logic        rx_full, rx_empty, rx_pop;
  logic [7:0]  rx_head;
  logic        tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]  tx_head, tx_push_data;

  assign unused_bits = ^bus_a[31:18];

  assign io_acc = rdy_in & (bus_a[17:16] == IO_WIN);
  assign mapped = (bus_a[15:3] == 13'd0);
  assign off    = bus_a[2:0];
  assign rx_pop = io_acc & mapped & ~bus_wr & (off == IO_UART);
  assign tx_pop = ~tx_empty & tx_ready;

  always_comb begin
    rdata_d      = rdata_q;
    sel_d        = 1'b0;
    snap_d       = snap_q;
    stop_d       = stop_q;
    ovf_d        = ovf_q;
    tx_push      = 1'b0;
    tx_push_data = bus_wdata;
    cnt_d        = cnt_q + 32'd1;

    if (io_acc && !bus_wr) begin
      sel_d   = 1'b1;
      rdata_d = 8'h00;
      if (mapped) begin
        case (off)
          IO_UART: if (!rx_empty) rdata_d = rx_head;
          IO_CNT0: begin
            rdata_d = cnt_q[7:0];
            snap_d  = cnt_q;
          end
          IO_CNT1, IO_CNT2, IO_CNT3: rdata_d = cnt_byte(snap_q, off[1:0]);
          default: rdata_d = 8'h00;
        endcase
      end
    end

    if (io_acc && bus_wr && mapped) begin
      case (off)
        IO_UART: tx_push = (bus_wdata != 8'h00);
        // A stop write also emits a 0x00 marker byte, bypassing the zero filter.
        IO_CNT0: begin
          stop_d       = 1'b1;
          tx_push      = 1'b1;
          tx_push_data = 8'h00;
        end
        default: tx_push = 1'b0;
      endcase
    end

    if (tx_push && tx_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rdata_q <= 8'h00;
      sel_q   <= 1'b0;
      cnt_q   <= 32'd0;
      snap_q  <= 32'd0;
      stop_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (rdy_in) begin
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      stop_q  <= stop_d;
      ovf_q   <= ovf_d;
    end
  end

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .rdy_i       (rdy_in),
    .push_i      (rx_valid),
    .push_data_i (rx_data),
    .pop_i       (rx_pop),
    .head_o      (rx_head),
    .full_o      (rx_full),
    .empty_o     (rx_empty)
  );

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .rdy_i       (rdy_in),
    .push_i      (tx_push),
    .push_data_i (tx_push_data),
    .pop_i       (tx_pop),
    .head_o      (tx_head),
    .full_o      (tx_full),
    .empty_o     (tx_empty)
  );

  assign bus_rdata   = rdata_q;
  assign io_sel      = sel_q;
  assign rx_ready    = ~rx_full;
  assign tx_valid    = ~tx_empty;
  assign tx_data     = tx_head;
  assign prog_stop   = stop_q;
  assign tx_overflow = ovf_q;

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder.
`timescale 1ns/1ps
module tb_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] bus_a;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        io_sel;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        prog_stop;
  logic        tx_overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_cnt;

  io_responder #(.RX_DEPTH(16), .TX_DEPTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .bus_a(bus_a), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .io_sel(io_sel),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .prog_stop(prog_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Reference cycle counter: free-running while rdy_in is high.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     m_cnt <= 32'd0;
    else if (rdy_in) m_cnt <= m_cnt + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_idle();
    bus_a = 32'h0; bus_wr = 1'b0; bus_wdata = 8'h00;
  endtask

  task automatic bus_rd(input logic [31:0] a);
    bus_a = a; bus_wr = 1'b0;
    tick();
  endtask

  task automatic bus_wrt(input logic [31:0] a, input logic [7:0] d);
    bus_a = a; bus_wr = 1'b1; bus_wdata = d;
    tick();
    bus_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_b;
    int guard;
    rst_in = 1'b0; rdy_in = 1'b1; bus_idle();
    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) tick();

    chk("rst_rdata",  bus_rdata,   8'h00);
    chk("rst_iosel",  io_sel,      1'b0);
    chk("rst_stop",   prog_stop,   1'b0);
    chk("rst_ovf",    tx_overflow, 1'b0);
    chk("rst_rxrdy",  rx_ready,    1'b1);
    chk("rst_txval",  tx_valid,    1'b0);
    rst_in = 1'b1;

    // Counter tear: start the 4-byte read when the live count is 0xFE.
    guard = 0;
    while (m_cnt != 32'hFE && guard < 1000) begin
      tick();
      guard++;
    end
    if (guard >= 1000) chk("cnt_wait", 0, 1);
    bus_rd(32'h0003_0004); chk("cnt_b0", bus_rdata, 8'hFE);
    bus_rd(32'h0003_0005); chk("cnt_b1", bus_rdata, 8'h00);
    bus_rd(32'h0003_0006); chk("cnt_b2", bus_rdata, 8'h00);
    bus_rd(32'h0003_0007); chk("cnt_b3", bus_rdata, 8'h00);
    chk("cnt_sel", io_sel, 1'b1);
    bus_idle(); tick();
    chk("idle_sel", io_sel, 1'b0);

    // RX path
    rx_valid = 1'b1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 1'b0;
    bus_rd(32'h0003_0000); chk("rx_b0", bus_rdata, 8'h41); chk("rx_sel0", io_sel, 1'b1);
    bus_rd(32'h0003_0000); chk("rx_b1", bus_rdata, 8'h42); chk("rx_sel1", io_sel, 1'b1);
    bus_rd(32'h0003_0000); chk("rx_empty", bus_rdata, 8'h00); chk("rx_sel2", io_sel, 1'b1);

    // Unmapped offsets and non-I/O addresses
    bus_rd(32'h0003_0001); chk("unm_off", bus_rdata, 8'h00); chk("unm_sel", io_sel, 1'b1);
    bus_rd(32'h0003_0008); chk("unm_hi", bus_rdata, 8'h00); chk("unm_hi_sel", io_sel, 1'b1);
    bus_rd(32'h0002_0000); chk("nonio_sel", io_sel, 1'b0);
    bus_idle();

    // TX path with zero filter
    bus_wrt(32'h0003_0000, 8'h00);
    chk("tx_zero", tx_valid, 1'b0);
    chk("wr_sel", io_sel, 1'b0);
    bus_wrt(32'h0003_0000, 8'h55);
    chk("tx_val", tx_valid, 1'b1);
    chk("tx_data", tx_data, 8'h55);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    chk("tx_drain", tx_valid, 1'b0);

    // TX overflow: 17 writes into 16 entries
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("ovf_before", tx_overflow, 1'b0);
      bus_wrt(32'h0003_0000, 8'(i + 1));
    end
    chk("ovf_after", tx_overflow, 1'b1);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", tx_data, 32'(i + 1));
      tick();
    end
    tx_ready = 1'b0;
    chk("ovf_empty", tx_valid, 1'b0);

    // Stop write, then rdy_in freeze
    bus_wrt(32'h0003_0004, 8'hAB);
    chk("stop_set", prog_stop, 1'b1);
    chk("stop_txv", tx_valid, 1'b1);
    chk("stop_txd", tx_data, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h77; tick();
    rx_data = 8'h78; tick();
    rx_valid = 1'b0;
    bus_rd(32'h0003_0000); chk("pre_frz", bus_rdata, 8'h77);
    rdy_in = 1'b0; rx_valid = 1'b1; rx_data = 8'h99; tx_ready = 1'b1;
    repeat (5) tick();
    chk("frz_rdata", bus_rdata, 8'h77);
    chk("frz_sel",   io_sel,    1'b1);
    chk("frz_txv",   tx_valid,  1'b1);
    chk("frz_txd",   tx_data,   8'h00);
    rdy_in = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0;
    bus_rd(32'h0003_0000); chk("post_frz0", bus_rdata, 8'h78);
    bus_rd(32'h0003_0000); chk("post_frz1", bus_rdata, 8'h00);
    exp_b = m_cnt[7:0];
    bus_rd(32'h0003_0004); chk("post_cnt", bus_rdata, exp_b);
    bus_idle();
    chk("post_txv", tx_valid, 1'b1);
    chk("stop_sticky", prog_stop, 1'b1);

    // Fill RX, then asynchronous reset mid-stream
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'hC0 + i);
      tick();
    end
    rx_valid = 1'b0;
    chk("rx_full", rx_ready, 1'b0);
    rst_in = 1'b0; #1;
    chk("arst_rxrdy", rx_ready,    1'b1);
    chk("arst_txv",   tx_valid,    1'b0);
    chk("arst_stop",  prog_stop,   1'b0);
    chk("arst_ovf",   tx_overflow, 1'b0);
    tick(); rst_in = 1'b1; tick();
    bus_rd(32'h0003_0000);
    chk("arst_rd", bus_rdata, 8'h00);
    chk("arst_sel", io_sel, 1'b1);
    bus_idle(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
